// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit path: the byte width used by the
// RX/TX datapaths, the default packet header base and the state encoding of
// the packet arbiter.
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] HDR_BASE_DEFAULT = 8'hA0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DONE
    } arb_state_t;

endpackage

// File: rtl/uart_tx_packet_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin search: returns the first set request bit found
// scanning upward from ptr, wrapping at N_REQ.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index the search starts from (highest priority this round)
//   grant - index of the winning requester (0 when nothing is found)
//   found - at least one request bit is set
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant,
    output logic             found
);

    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_packet_arbiter.sv
// uart_tx_packet_arbiter
// Shares the UART TX byte datapath among N_REQ packet sources. Whole packets
// are granted round-robin and framed as header (HDR_BASE | id), payload, then
// an XOR checksum byte. A source that stalls mid-packet for TIMEOUT cycles has
// its packet closed with an inverted checksum so the receiver drops it.
//
// Ports:
//   clk, reset_b       - clock, asynchronous active-low reset
//   in_valid/in_last   - per-requester byte valid / last-of-packet flag
//   in_data            - per-requester byte, requester i at [8*i+7:8*i]
//   in_ready           - per-requester accept strobe
//   tx_valid/tx_data   - byte presented to the UART TX datapath
//   tx_ready           - UART TX datapath accepts the byte
//   busy               - packet in progress
//   grant_id           - current / last granted requester
//   err_abort          - one-cycle pulse when a packet is aborted by timeout
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no packet; arbitrate among in_valid
// ST_HDR     | load header byte once the output register is free
// ST_PAYLOAD | forward granted requester's bytes, run the idle timer
// ST_CSUM    | load checksum (inverted if aborted)
// ST_DONE    | wait for the checksum to leave, advance rr pointer
module uart_tx_packet_arbiter
    import uart_pkg::*;
#(
    parameter  int                N_REQ    = 4,
    parameter  logic [BYTE_W-1:0] HDR_BASE = HDR_BASE_DEFAULT,
    parameter  int                TIMEOUT  = 1024,
    localparam int                ID_W     = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_b,
    input  logic [N_REQ-1:0]          in_valid,
    input  logic [N_REQ-1:0]          in_last,
    input  logic [BYTE_W*N_REQ-1:0]   in_data,
    output logic [N_REQ-1:0]          in_ready,
    output logic                      tx_valid,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      err_abort
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t         state_q, state_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BYTE_W-1:0]  csum_q, csum_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               abort_q, abort_d;
    logic               tx_valid_q, tx_valid_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic               err_abort_q, err_abort_d;

    logic               out_free;
    logic               load;
    logic [BYTE_W-1:0]  load_byte;
    logic [BYTE_W-1:0]  hdr_byte;
    logic               sel_valid;
    logic               sel_last;
    logic [BYTE_W-1:0]  sel_data;
    logic [ID_W-1:0]    arb_grant;
    logic               arb_found;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req   (in_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .found (arb_found)
    );

    // The output register can take a new byte if empty or draining this cycle.
    assign out_free  = !tx_valid_q || tx_ready;
    assign sel_valid = in_valid[grant_id_q];
    assign sel_last  = in_last[grant_id_q];
    assign sel_data  = in_data[BYTE_W*int'(grant_id_q) +: BYTE_W];
    assign hdr_byte  = HDR_BASE | {{(BYTE_W-ID_W){1'b0}}, grant_id_q};

    always_comb begin
        in_ready = '0;
        if (state_q == ST_PAYLOAD) begin
            in_ready[grant_id_q] = out_free;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        csum_d      = csum_q;
        to_cnt_d    = to_cnt_q;
        abort_d     = abort_q;
        err_abort_d = 1'b0;
        load        = 1'b0;
        load_byte   = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_id_d = arb_grant;
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_byte = hdr_byte;
                    csum_d    = hdr_byte;
                    to_cnt_d  = '0;
                    state_d   = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                // Timer only runs while the output could have accepted a byte,
                // so downstream backpressure never causes an abort.
                if (out_free) begin
                    if (sel_valid) begin
                        load      = 1'b1;
                        load_byte = sel_data;
                        csum_d    = csum_q ^ sel_data;
                        to_cnt_d  = '0;
                        if (sel_last) begin
                            state_d = ST_CSUM;
                        end
                    end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        to_cnt_d    = '0;
                        abort_d     = 1'b1;
                        err_abort_d = 1'b1;
                        state_d     = ST_CSUM;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end
            ST_CSUM: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_byte = abort_q ? ~csum_q : csum_q;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (tx_valid_q && tx_ready) begin
                    rr_ptr_d = (grant_id_q == ID_W'(N_REQ - 1)) ? '0
                                                                : grant_id_q + ID_W'(1);
                    abort_d  = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (load) begin
            tx_valid_d = 1'b1;
            tx_data_d  = load_byte;
        end else if (tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= ST_IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            csum_q      <= '0;
            to_cnt_q    <= '0;
            abort_q     <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            err_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            csum_q      <= csum_d;
            to_cnt_q    <= to_cnt_d;
            abort_q     <= abort_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            err_abort_q <= err_abort_d;
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign grant_id  = grant_id_q;
    assign err_abort = err_abort_q;

endmodule

// File: tb/tb_uart_tx_packet_arbiter.sv
// Directed testbench for uart_tx_packet_arbiter (N_REQ=4, TIMEOUT=8).
module tb_uart_tx_packet_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic          clk;
    logic          reset_b;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_last;
    logic [8*N-1:0] in_data;
    logic [N-1:0]  in_ready;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          busy;
    logic [1:0]    grant_id;
    logic          err_abort;

    uart_tx_packet_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .grant_id  (grant_id),
        .err_abort (err_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // source model
    logic [7:0] src_data [N][16];
    int         src_len  [N];
    int         src_idx  [N];
    bit         src_en   [N];
    bit         src_last [N];

    // monitor state
    logic [7:0] txq [$];
    int         txc [$];
    int         cyc = 0;
    int         viol = 0;
    int         stall_cnt = 0;
    int         abort_cnt = 0;
    int         err_cyc = 0;
    int         acc_cyc [N];
    bit         rdy2_seen = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = 8'h00;

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_en[i] && src_idx[i] < src_len[i]) begin
                in_valid[i]      = 1'b1;
                in_data[8*i +: 8] = src_data[i][src_idx[i]];
                in_last[i]       = src_last[i] && (src_idx[i] == src_len[i] - 1);
            end else begin
                in_valid[i]      = 1'b0;
                in_data[8*i +: 8] = 8'h00;
                in_last[i]       = 1'b0;
            end
        end
    endtask

    task automatic load_src(input int id, input logic [7:0] b [$], input bit last_en);
        for (int k = 0; k < b.size(); k++) src_data[id][k] = b[k];
        src_len[id]  = b.size();
        src_idx[id]  = 0;
        src_last[id] = last_en;
        src_en[id]   = 1'b1;
    endtask

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < N; i++)
            if (src_en[i] && src_idx[i] < src_len[i]) p = 1;
        return p;
    endfunction

    // One clock: sample at negedge, advance sources after the posedge.
    task automatic tick();
        bit acc [N];
        @(negedge clk);
        if (prev_stall && (!tx_valid || tx_data !== prev_data)) viol++;
        if (tx_valid && !tx_ready) begin
            stall_cnt++;
            if (in_ready != '0) viol++;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (in_ready[2]) rdy2_seen = 1;
        if (err_abort) begin
            abort_cnt++;
            err_cyc = cyc;
        end
        if (tx_valid && tx_ready) begin
            txq.push_back(tx_data);
            txc.push_back(cyc + 1);
        end
        for (int i = 0; i < N; i++) begin
            acc[i] = in_valid[i] && in_ready[i];
            if (acc[i]) acc_cyc[i] = cyc + 1;
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i]) src_idx[i]++;
        drive_inputs();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((busy || pending()) && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (busy || pending()) begin
            n_fail++;
            $display("FAIL %s_idle: still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic clear_mon();
        txq.delete();
        txc.delete();
        viol = 0;
        stall_cnt = 0;
        abort_cnt = 0;
        prev_stall = 0;
        for (int i = 0; i < N; i++) src_en[i] = 1'b0;
    endtask

    task automatic test_reset();
        reset_b  = 1'b0;
        tx_ready = 1'b1;
        clear_mon();
        drive_inputs();
        tick();
        n_checks++; if (tx_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (tx_data !== 8'h00)  begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        n_checks++; if (in_ready !== 4'h0)  begin n_fail++; $display("FAIL rst_in_ready: got %h want 0", in_ready); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (grant_id !== 2'd0)  begin n_fail++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
        n_checks++; if (err_abort !== 1'b0) begin n_fail++; $display("FAIL rst_err_abort: got %b want 0", err_abort); end
        reset_b = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp [$] = '{8'hA0, 8'h00, 8'hA0, 8'hA1, 8'h10, 8'hB1,
                                8'hA2, 8'h20, 8'h82, 8'hA3, 8'h30, 8'h93};
        logic [7:0] got;
        clear_mon();
        for (int i = 0; i < N; i++) begin
            logic [7:0] b [$];
            b.push_back(8'(i * 16));
            load_src(i, b, 1'b1);
        end
        drive_inputs();
        wait_idle(100, "rr");
        n_checks++; if (txq.size() != exp.size()) begin n_fail++; $display("FAIL rr_len: got %0d want %0d", txq.size(), exp.size()); end
        for (int k = 0; k < exp.size(); k++) begin
            got = (k < txq.size()) ? txq[k] : 8'hxx;
            n_checks++; if (got !== exp[k]) begin n_fail++; $display("FAIL rr_byte%0d: got %h want %h", k, got, exp[k]); end
        end
        // pointer back at 0; only requester 3 asks
        clear_mon();
        begin
            logic [7:0] b [$] = '{8'h30};
            load_src(3, b, 1'b1);
        end
        drive_inputs();
        tick();
        n_checks++; if (grant_id !== 2'd3) begin n_fail++; $display("FAIL rr_only3_grant: got %0d want 3", grant_id); end
        wait_idle(40, "rr3");
        exp = '{8'hA3, 8'h30, 8'h93};
        n_checks++; if (txq.size() != 3) begin n_fail++; $display("FAIL rr3_len: got %0d want 3", txq.size()); end
        for (int k = 0; k < 3; k++) begin
            got = (k < txq.size()) ? txq[k] : 8'hxx;
            n_checks++; if (got !== exp[k]) begin n_fail++; $display("FAIL rr3_byte%0d: got %h want %h", k, got, exp[k]); end
        end
    endtask

    task automatic test_single();
        logic [7:0] b [$] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] exp [$] = '{8'hA1, 8'h11, 8'h22, 8'h33, 8'hA1};
        logic [7:0] got;
        clear_mon();
        load_src(1, b, 1'b1);
        drive_inputs();
        tick();
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL single_hdr_early: got %b want 0", tx_valid); end
        tick();
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA1) begin n_fail++; $display("FAIL single_hdr_lat: got v=%b d=%h want v=1 d=a1", tx_valid, tx_data); end
        wait_idle(40, "single");
        n_checks++; if (txq.size() != 5) begin n_fail++; $display("FAIL single_len: got %0d want 5", txq.size()); end
        for (int k = 0; k < 5; k++) begin
            got = (k < txq.size()) ? txq[k] : 8'hxx;
            n_checks++; if (got !== exp[k]) begin n_fail++; $display("FAIL single_byte%0d: got %h want %h", k, got, exp[k]); end
        end
        for (int k = 1; k < txc.size(); k++) begin
            n_checks++; if (txc[k] != txc[0] + k) begin n_fail++; $display("FAIL single_gap%0d: got cycle %0d want %0d", k, txc[k], txc[0] + k); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [7:0] b [$] = '{8'h5A, 8'h6B, 8'h7C};
        logic [7:0] exp [$] = '{8'hA2, 8'h5A, 8'h6B, 8'h7C, 8'hEF};
        bit pat [9] = '{1, 0, 0, 1, 0, 1, 0, 0, 1};
        logic [7:0] got;
        clear_mon();
        tx_ready = 1'b1;
        load_src(2, b, 1'b1);
        drive_inputs();
        tick();
        tick();
        for (int k = 0; k < 9; k++) begin
            tx_ready = pat[k];
            #1;
            if (!pat[k] && tx_valid) begin
                n_checks++; if (in_ready !== 4'h0) begin n_fail++; $display("FAIL bp_in_ready%0d: got %h want 0", k, in_ready); end
            end
            tick();
        end
        tx_ready = 1'b1;
        wait_idle(40, "bp");
        n_checks++; if (viol != 0) begin n_fail++; $display("FAIL bp_stall_violations: got %0d want 0", viol); end
        n_checks++; if (stall_cnt < 3) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d want >=3", stall_cnt); end
        n_checks++; if (txq.size() != 5) begin n_fail++; $display("FAIL bp_len: got %0d want 5", txq.size()); end
        for (int k = 0; k < 5; k++) begin
            got = (k < txq.size()) ? txq[k] : 8'hxx;
            n_checks++; if (got !== exp[k]) begin n_fail++; $display("FAIL bp_byte%0d: got %h want %h", k, got, exp[k]); end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b0 [$] = '{8'h55};
        logic [7:0] b1 [$] = '{8'h99};
        logic [7:0] exp [$] = '{8'hA0, 8'h55, 8'h0A, 8'hA1, 8'h99, 8'h38};
        logic [7:0] got;
        clear_mon();
        tx_ready = 1'b1;
        load_src(0, b0, 1'b0);
        load_src(1, b1, 1'b1);
        drive_inputs();
        wait_idle(80, "to");
        n_checks++; if (abort_cnt != 1) begin n_fail++; $display("FAIL to_pulse_cycles: got %0d want 1", abort_cnt); end
        n_checks++; if (err_cyc - acc_cyc[0] != TO) begin n_fail++; $display("FAIL to_delay: got %0d want %0d", err_cyc - acc_cyc[0], TO); end
        n_checks++; if (txq.size() != 6) begin n_fail++; $display("FAIL to_len: got %0d want 6", txq.size()); end
        for (int k = 0; k < 6; k++) begin
            got = (k < txq.size()) ? txq[k] : 8'hxx;
            n_checks++; if (got !== exp[k]) begin n_fail++; $display("FAIL to_byte%0d: got %h want %h", k, got, exp[k]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b3 [$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        logic [7:0] c1 [$] = '{8'hC1};
        logic [7:0] c3 [$] = '{8'hC3};
        logic [7:0] exp [$] = '{8'hA1, 8'hC1, 8'h60, 8'hA3, 8'hC3, 8'h60};
        logic [7:0] got;
        clear_mon();
        tx_ready = 1'b1;
        load_src(3, b3, 1'b1);
        drive_inputs();
        repeat (4) tick();
        n_checks++; if (tx_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rm_pre: got v=%b busy=%b want 1/1", tx_valid, busy); end
        reset_b = 1'b0;
        #1;
        n_checks++; if (tx_valid !== 1'b0)  begin n_fail++; $display("FAIL rm_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
        n_checks++; if (in_ready !== 4'h0)  begin n_fail++; $display("FAIL rm_in_ready: got %h want 0", in_ready); end
        n_checks++; if (grant_id !== 2'd0)  begin n_fail++; $display("FAIL rm_grant_id: got %0d want 0", grant_id); end
        n_checks++; if (tx_data !== 8'h00)  begin n_fail++; $display("FAIL rm_tx_data: got %h want 00", tx_data); end
        clear_mon();
        drive_inputs();
        tick();
        tick();
        reset_b = 1'b1;
        clear_mon();
        load_src(1, c1, 1'b1);
        load_src(3, c3, 1'b1);
        drive_inputs();
        tick();
        n_checks++; if (tx_valid !== 1'b0 || grant_id !== 2'd1) begin n_fail++; $display("FAIL rm_grant: got v=%b id=%0d want v=0 id=1", tx_valid, grant_id); end
        tick();
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA1) begin n_fail++; $display("FAIL rm_hdr: got v=%b d=%h want v=1 d=a1", tx_valid, tx_data); end
        wait_idle(40, "rm");
        n_checks++; if (txq.size() != 6) begin n_fail++; $display("FAIL rm_len: got %0d want 6", txq.size()); end
        for (int k = 0; k < 6; k++) begin
            got = (k < txq.size()) ? txq[k] : 8'hxx;
            n_checks++; if (got !== exp[k]) begin n_fail++; $display("FAIL rm_byte%0d: got %h want %h", k, got, exp[k]); end
        end
    endtask

    task automatic test_pulse();
        logic [7:0] b0 [$] = '{8'h01, 8'h02, 8'h03, 8'h04};
        logic [7:0] b2 [$] = '{8'hEE};
        logic [7:0] exp [$] = '{8'hA0, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA4};
        logic [7:0] got;
        clear_mon();
        rdy2_seen = 0;
        tx_ready = 1'b1;
        load_src(0, b0, 1'b1);
        drive_inputs();
        tick();
        tick();
        load_src(2, b2, 1'b1);
        drive_inputs();
        tick();
        src_en[2] = 1'b0;
        drive_inputs();
        wait_idle(40, "pulse");
        repeat (3) tick();
        n_checks++; if (rdy2_seen !== 1'b0) begin n_fail++; $display("FAIL pulse_ready2: got %b want 0", rdy2_seen); end
        n_checks++; if (grant_id !== 2'd0)  begin n_fail++; $display("FAIL pulse_grant: got %0d want 0", grant_id); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL pulse_busy: got %b want 0", busy); end
        n_checks++; if (txq.size() != 6) begin n_fail++; $display("FAIL pulse_len: got %0d want 6", txq.size()); end
        for (int k = 0; k < 6; k++) begin
            got = (k < txq.size()) ? txq[k] : 8'hxx;
            n_checks++; if (got !== exp[k]) begin n_fail++; $display("FAIL pulse_byte%0d: got %h want %h", k, got, exp[k]); end
        end
    endtask

    initial begin
        in_valid = '0;
        in_last  = '0;
        in_data  = '0;
        tx_ready = 1'b1;
        reset_b  = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_idx[i] = 0;
            src_en[i]  = 1'b0;
            src_last[i] = 1'b0;
            acc_cyc[i] = 0;
        end
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
